data_cache: RTL

//  Direct-mapped, write-through, no-write-allocate data cache, one per compute core.

---
 rtl/data_cache.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// One word per line. Read hits answer in one cycle without touching memory.
// Read misses fetch the word from memory and fill the line. Every write is
// passed through to memory, and the line is updated only when the write hits.
// Read hits and read misses are counted in two saturating 16-bit counters.
//
// Ports (the core side and the memory side both use valid/ready handshakes):
//   clk, reset              clock and asynchronous active-high reset
//   flush                   1-cycle pulse that invalidates every line
//   core_read_*             core read request: valid/address in, ready/data out
//   core_write_*            core write request: valid/address/data in, ready out
//   mem_read_*              line fill request to memory: valid/address out,
//                           ready/data in
//   mem_write_*             write-through request to memory: valid/address/data
//                           out, ready in
//   hit_count, miss_count   read hit and read miss counters
module data_cache #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_LINES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 core_read_valid,
  input  logic [ADDR_BITS-1:0] core_read_address,
  output logic                 core_read_ready,
  output logic [DATA_BITS-1:0] core_read_data,
  input  logic                 core_write_valid,
  input  logic [ADDR_BITS-1:0] core_write_address,
  input  logic [DATA_BITS-1:0] core_write_data,
  output logic                 core_write_ready,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = ADDR_BITS - IDX;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic                   resp_rd_q, resp_rd_d;      // RESPOND is answering a read
  logic                   flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   rd_ready_q, rd_ready_d;
  logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   mrv_q, mrv_d;
  logic [ADDR_BITS-1:0]   mra_q, mra_d;
  logic                   mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]   mwa_q, mwa_d;
  logic [DATA_BITS-1:0]   mwd_q, mwd_d;
  logic [15:0]            hit_q, hit_d;
  logic [15:0]            miss_q, miss_d;

  // Tag and data storage need no reset; the valid bits qualify them.
  logic [TAG-1:0]         tag_mem  [NUM_LINES];
  logic [DATA_BITS-1:0]   data_mem [NUM_LINES];

  logic                   line_we;
  logic [IDX-1:0]         line_idx;
  logic [TAG-1:0]         line_tag;
  logic [DATA_BITS-1:0]   line_wdata;

  logic [IDX-1:0]         rd_idx, wr_idx, fill_idx;
  logic [TAG-1:0]         rd_tag, wr_tag, fill_tag;
  logic                   rd_hit, wr_hit;

  assign rd_idx   = core_read_address[IDX-1:0];
  assign rd_tag   = core_read_address[ADDR_BITS-1:IDX];
  assign wr_idx   = core_write_address[IDX-1:0];
  assign wr_tag   = core_write_address[ADDR_BITS-1:IDX];
  assign fill_idx = mra_q[IDX-1:0];
  assign fill_tag = mra_q[ADDR_BITS-1:IDX];
  assign rd_hit   = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign wr_hit   = valid_q[wr_idx] && (tag_mem[wr_idx] == wr_tag);

  always_comb begin
    state_d      = state_q;
    resp_rd_d    = resp_rd_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    rd_ready_d   = rd_ready_q;
    rd_data_d    = rd_data_q;
    wr_ready_d   = wr_ready_q;
    mrv_d        = mrv_q;
    mra_d        = mra_q;
    mwv_d        = mwv_q;
    mwa_d        = mwa_q;
    mwd_d        = mwd_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    line_we      = 1'b0;
    line_idx     = rd_idx;
    line_tag     = rd_tag;
    line_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // A flush (pending or arriving now) takes this cycle by itself.
        if (flush_pend_q || flush) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (core_read_valid) begin
          if (rd_hit) begin
            rd_data_d  = data_mem[rd_idx];
            rd_ready_d = 1'b1;
            resp_rd_d  = 1'b1;
            hit_d      = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
            state_d    = RESPOND;
          end else begin
            mrv_d   = 1'b1;
            mra_d   = core_read_address;
            miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
            state_d = RD_MISS;
          end
        end else if (core_write_valid) begin
          mwv_d = 1'b1;
          mwa_d = core_write_address;
          mwd_d = core_write_data;
          if (wr_hit) begin
            line_we    = 1'b1;
            line_idx   = wr_idx;
            line_tag   = wr_tag;
            line_wdata = core_write_data;
          end
          state_d = WR_THRU;
        end
      end
      RD_MISS: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_read_ready) begin
          line_we           = 1'b1;
          line_idx          = fill_idx;
          line_tag          = fill_tag;
          line_wdata        = mem_read_data;
          valid_d[fill_idx] = 1'b1;
          rd_data_d         = mem_read_data;
          rd_ready_d        = 1'b1;
          resp_rd_d         = 1'b1;
          mrv_d             = 1'b0;
          state_d           = RESPOND;
        end
      end
      WR_THRU: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_write_ready) begin
          mwv_d      = 1'b0;
          wr_ready_d = 1'b1;
          resp_rd_d  = 1'b0;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        if (flush) flush_pend_d = 1'b1;
        if (resp_rd_q) begin
          if (!core_read_valid) begin
            rd_ready_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (!core_write_valid) begin
          wr_ready_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_rd_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      rd_ready_q   <= 1'b0;
      rd_data_q    <= '0;
      wr_ready_q   <= 1'b0;
      mrv_q        <= 1'b0;
      mra_q        <= '0;
      mwv_q        <= 1'b0;
      mwa_q        <= '0;
      mwd_q        <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      resp_rd_q    <= resp_rd_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rd_ready_q   <= rd_ready_d;
      rd_data_q    <= rd_data_d;
      wr_ready_q   <= wr_ready_d;
      mrv_q        <= mrv_d;
      mra_q        <= mra_d;
      mwv_q        <= mwv_d;
      mwa_q        <= mwa_d;
      mwd_q        <= mwd_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_wdata;
    end
  end

  assign core_read_ready   = rd_ready_q;
  assign core_read_data    = rd_data_q;
  assign core_write_ready  = wr_ready_q;
  assign mem_read_valid    = mrv_q;
  assign mem_read_address  = mra_q;
  assign mem_write_valid   = mwv_q;
  assign mem_write_address = mwa_q;
  assign mem_write_data    = mwd_q;
  assign hit_count         = hit_q;
  assign miss_count        = miss_q;

endmodule
